// File: rtl/cnn_uart_pkg.sv
// Shared UART definitions: transmit state encoding, data width, default baud divisor.
// The PARITY state is always encoded; it is only reachable when UART_TX_PARITY_EN is defined.
package cnn_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 2604;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the trmt strobe and the frame engine; first-word-fall-through head.
// Pointers carry one extra MSB so full and empty are told apart without a counter.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 stop bit, fed by a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import cnn_uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       ovf
);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t      state_r, state_nxt_s;
    logic [BW-1:0]  baud_r, baud_nxt_s;
    logic [2:0]     bit_r, bit_nxt_s;
    logic [7:0]     shift_r, shift_nxt_s;
    logic           tx_r, tx_nxt_s;
    logic           done_r, done_nxt_s;
    logic           ovf_r;
    logic           pop_s;
    logic           baud_end_s;
    logic [7:0]     fifo_dout_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
`ifdef UART_TX_PARITY_EN
    logic           parity_r, parity_nxt_s;
`endif

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (RST_n),
        .push  (trmt),
        .pop   (pop_s),
        .din   (tx_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign baud_end_s = (baud_r == BAUD_LAST);

    // Next-state, datapath and next TX level; TX is set for the state being entered.
    always_comb begin
        state_nxt_s = state_r;
        baud_nxt_s  = baud_end_s ? '0 : (baud_r + BAUD_ONE);
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        tx_nxt_s    = tx_r;
        done_nxt_s  = 1'b0;
        pop_s       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                baud_nxt_s = '0;
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_dout_s;
`ifdef UART_TX_PARITY_EN
                    parity_nxt_s = even_parity(fifo_dout_s);
`endif
                    state_nxt_s = START;
                    tx_nxt_s    = 1'b0;
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            START: begin
                if (baud_end_s) begin
                    state_nxt_s = DATA;
                    bit_nxt_s   = 3'd0;
                    tx_nxt_s    = shift_r[0];
                end else begin
                    tx_nxt_s = 1'b0;
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    if (bit_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt_s = PARITY;
                        tx_nxt_s    = parity_r;
`else
                        state_nxt_s = STOP;
                        tx_nxt_s    = 1'b1;
`endif
                    end else begin
                        shift_nxt_s = shift_r >> 1;
                        bit_nxt_s   = bit_r + 3'd1;
                        tx_nxt_s    = shift_r[1];
                    end
                end else begin
                    tx_nxt_s = shift_r[0];
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (baud_end_s) begin
                    state_nxt_s = STOP;
                    tx_nxt_s    = 1'b1;
                end else begin
                    tx_nxt_s = parity_r;
                end
`else
                state_nxt_s = IDLE;
                tx_nxt_s    = 1'b1;
`endif
            end
            STOP: begin
                if (baud_end_s) begin
                    done_nxt_s = 1'b1;
                    // Chain straight into the next frame so queued bytes leave no idle gap.
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = fifo_dout_s;
`ifdef UART_TX_PARITY_EN
                        parity_nxt_s = even_parity(fifo_dout_s);
`endif
                        state_nxt_s = START;
                        tx_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                        tx_nxt_s    = 1'b1;
                    end
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                baud_nxt_s  = '0;
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

    // Frame engine registers and registered outputs.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            baud_r  <= baud_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            tx_r    <= tx_nxt_s;
            done_r  <= done_nxt_s;
            if (trmt && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_nxt_s;
`endif
        end
    end

    assign TX        = tx_r;
    assign tx_done   = done_r;
    assign tx_busy   = (state_r != IDLE) | ~fifo_empty_s;
    assign fifo_full = fifo_full_s;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line-level model (queue of per-clock TX levels) checked every cycle,
// plus directed frame, back-to-back, overflow, reset and randomized traffic scenarios.
module tb_uart_tx;
    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BAUD;

    logic       clk     = 1'b0;
    logic       RST_n   = 1'b0;
    logic       trmt    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX, tx_done, tx_busy, fifo_full, ovf;

    int n_checks  = 0;
    int n_errors  = 0;
    int done_seen = 0;
    int busy_seen = 0;

    typedef struct packed {
        logic tx;
        logic first;
        logic last;
    } seg_t;

    seg_t line_q[$];
    int   m_cnt    = 0;
    logic m_ovf    = 1'b0;
    logic m_done   = 1'b0;
    int   m_frames = 0;

    uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .RST_n     (RST_n),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .TX        (TX),
        .tx_done   (tx_done),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .ovf       (ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endtask

    // Frame = start, 8 data bits LSB first, optional even parity, stop; each held BAUD clocks.
    task automatic append_frame(input logic [7:0] b);
        logic [10:0] bits;
        seg_t        s;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int c = 0; c < BAUD; c++) begin
                s.tx    = bits[k];
                s.first = (k == 0) && (c == 0);
                s.last  = (k == FRAME_BITS - 1) && (c == BAUD - 1);
                line_q.push_back(s);
            end
        end
    endtask

    task automatic model_step();
        seg_t cur;
        logic popped;
        if (!RST_n) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (line_q.size() > 0) begin
            cur    = line_q.pop_front();
            m_done = cur.last;
        end
        popped = (line_q.size() > 0) && line_q[0].first;
        if (trmt) begin
            if ((m_cnt < DEPTH) || popped) begin
                if (line_q.size() == 0) begin
                    cur = '{tx: 1'b1, first: 1'b0, last: 1'b0};
                    line_q.push_back(cur);
                end
                append_frame(tx_data);
                m_cnt++;
                m_frames++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (popped) m_cnt--;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge RST_n);
        model_reset();
    end

    // Per-cycle comparison of all outputs against the line model.
    initial forever begin
        @(negedge clk);
        check_val("tx",       TX,        (line_q.size() > 0) ? line_q[0].tx : 1'b1);
        check_val("tx_busy",  tx_busy,   line_q.size() > 0);
        check_val("tx_done",  tx_done,   m_done);
        check_val("full",     fifo_full, m_cnt == DEPTH);
        check_val("ovf",      ovf,       m_ovf);
        if (tx_done === 1'b1) done_seen++;
        if (tx_busy === 1'b1) busy_seen++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        trmt    = 1'b1;
        tx_data = b;
        @(negedge clk);
        trmt    = 1'b0;
    endtask

    // Call right after send_byte on an idle line; samples each bit at its middle.
    task automatic sample_frame(output logic [10:0] v);
        v = '0;
        @(posedge clk);
        for (int k = 0; k < FRAME_BITS; k++) begin
            repeat (2) @(posedge clk);
            #1 v[k] = TX;
            repeat (2) @(posedge clk);
        end
    endtask

    initial begin
        logic [10:0] v;
        int d0, b0, f0;

        RST_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RST_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("idle_tx", TX, 1'b1);
        check_val("idle_busy", tx_busy, 1'b0);

        // Single 0x35 frame
        d0 = done_seen;
        b0 = busy_seen;
        send_byte(8'h35);
        sample_frame(v);
`ifdef UART_TX_PARITY_EN
        check_val("frame_35", v, {1'b1, 1'b0, 8'h35, 1'b0});
`else
        check_val("frame_35", v, {1'b1, 8'h35, 1'b0});
`endif
        repeat (5) @(negedge clk);
        check_val("single_done_cnt", done_seen - d0, 1);
        check_val("single_busy_clks", busy_seen - b0, FRAME_CLKS + 1);

        // Back-to-back 0x00, 0xFF, 0xA5
        d0 = done_seen;
        b0 = busy_seen;
        @(negedge clk); trmt = 1'b1; tx_data = 8'h00;
        @(negedge clk); tx_data = 8'hFF;
        @(negedge clk); tx_data = 8'hA5;
        @(negedge clk); trmt = 1'b0;
        repeat (3 * FRAME_CLKS + 10) @(negedge clk);
        check_val("b2b_done_cnt", done_seen - d0, 3);
        check_val("b2b_busy_clks", busy_seen - b0, 3 * FRAME_CLKS + 1);

        // Overflow: six pushes into a depth-4 FIFO
        d0 = done_seen;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            trmt    = 1'b1;
            tx_data = 8'(i);
        end
        @(negedge clk);
        trmt = 1'b0;
        check_val("ovf_set", ovf, 1'b1);
        repeat (5 * FRAME_CLKS + 20) @(negedge clk);
        check_val("ovf_done_cnt", done_seen - d0, 5);
        check_val("ovf_sticky", ovf, 1'b1);

        // Reset 13 clocks into a 0x00 frame
        send_byte(8'h00);
        @(posedge clk);
        repeat (13) @(posedge clk);
        #2 RST_n = 1'b0;
        #1;
        check_val("rst_tx_async", TX, 1'b1);
        check_val("rst_busy", tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        RST_n = 1'b1;
        d0 = done_seen;
        repeat (2 * FRAME_CLKS) @(negedge clk);
        check_val("rst_no_done", done_seen - d0, 0);
        check_val("rst_ovf_clr", ovf, 1'b0);

`ifdef UART_TX_PARITY_EN
        // Odd number of ones gives parity bit 1
        d0 = done_seen;
        send_byte(8'h07);
        sample_frame(v);
        check_val("frame_07", v, {1'b1, 1'b1, 8'h07, 1'b0});
        repeat (5) @(negedge clk);
        check_val("par_done_cnt", done_seen - d0, 1);
`endif

        // Randomized traffic, including bursts that overflow
        f0 = m_frames;
        d0 = done_seen;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            trmt    = ($urandom_range(0, 5) == 0);
            tx_data = 8'($urandom);
        end
        @(negedge clk);
        trmt = 1'b0;
        repeat ((DEPTH + 2) * FRAME_CLKS) @(negedge clk);
        check_val("rand_frames", done_seen - d0, m_frames - f0);
        check_val("rand_drained", tx_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
